l_host_pipe_bridge: RTL and testbench
=====================================

// Module: l_host_pipe_bridge
// PURPOSE
//  Host-side endpoint of the 144-bit portal pipe carried by the top-level request/indication ports.
//  Serializes each outgoing indication message into a 32-bit host word stream.
//  Reassembles incoming 32-bit host words into one 144-bit request message.
//  Sits between the host bus adapter and the design top; one message buffered per direction.
// PARAMETERS
//  HDR_W      16   header width; header = {methodId[15:8], lenWords[7:0]}
//  PAYLOAD_W  128  payload width
//  WORD_W     32   host word width
//  MAX_WORDS  4    PAYLOAD_W/WORD_W; largest legal lenWords
// PORTS
//  CLK                   in   1    clock
//  RST                   in   1    reset, asynchronous, active-high
//  indication$enq__ENA   in   1    indication message offered (only while __RDY=1)
//  indication$enq$v      in   144  {header[143:128], payload[127:0]}
//  indication$enq__RDY   out  1    able to accept an indication message
//  hostOut$enq__ENA      out  1    host word transfer
//  hostOut$enq$v         out  32   host word
//  hostOut$enq__RDY      in   1    host can take a word
//  hostIn$enq__ENA       in   1    host word transfer (only while __RDY=1)
//  hostIn$enq$v          in   32   host word
//  hostIn$enq__RDY       out  1    able to accept a host word
//  request$enq__ENA      out  1    request message transfer
//  request$enq$v         out  144  assembled request message
//  request$enq__RDY      in   1    downstream can take a request message
//  error                 out  1    sticky: a header with lenWords>MAX_WORDS was seen
// BEHAVIOUR
//  Handshake: transfer occurs in a cycle where __ENA=1; an output __ENA = internal valid & peer __RDY.
//   Inputs are sampled only when our __RDY=1. TX and RX halves are fully independent.
//  Reset (async, RST=1): TX->IDLE, RX->HDR, count=0, error=0, all ENA=0, indication$enq__RDY=1,
//   hostIn$enq__RDY=1, data outputs 0. A reset mid-message discards any partial message.
//  Length rule: len = min(lenWords, MAX_WORDS); lenWords>MAX_WORDS sets error (cleared only by reset).
//  Payload word k (0-based) = payload[32k+31:32k]; LSW first.
//  TX FSM (indication -> host):
//   IDLE: indication$enq__RDY=1; on ENA latch message, go HDR.
//   HDR:  hostOut$enq$v = {16'h0, header}; on transfer: len==0 -> IDLE, else k=0, DATA.
//   DATA: hostOut$enq$v = word k; on transfer: k==len-1 -> IDLE, else k++.
//   Latency: message accepted in cycle N -> header word presentable in N+1; indication$enq__RDY=0
//    outside IDLE, so back-to-back messages need len+2 cycles each with host always ready.
//   Host stall (hostOut$enq__RDY=0) holds state and value indefinitely.
//  RX FSM (host -> request):
//   HDR:  hostIn$enq__RDY=1; on ENA capture v[15:0] as header (v[31:16] ignored), clear payload;
//         len==0 -> FULL, else k=0, DATA.
//   DATA: hostIn$enq__RDY=1; on ENA write word k; k==len-1 -> FULL, else k++.
//   FULL: hostIn$enq__RDY=0; request$enq$v = {header, payload}, unwritten words 0;
//         on transfer -> HDR. Clamped header is forwarded unmodified (lenWords as received).
//   Last word received in cycle N -> request$enq__ENA possible in N+1.
//  No simultaneous-event hazards: each FSM has one transfer source per state.
// STRUCTURE
//  Shared package bscant_pkg: HDR_W, PAYLOAD_W, WORD_W, MAX_WORDS, PIPE_W=HDR_W+PAYLOAD_W,
//   packed typedef pipe_hdr_t {methodId[7:0], lenWords[7:0]}, TX/RX state enums.
//  One sub-module: l_pipe_word_ser (TX half, instantiated once); RX half and error flag in top.
// TESTING
//  1 TX: indication v={16'h0203, payload 128'h4444_3333_2222_1111...} with host always ready ->
//    words 0x00000203, word0, word1, word2 in consecutive cycles, then indication$enq__RDY=1.
//  2 RX: host words 0x00000102, 0xAAAA0001, 0xBBBB0002 -> request$enq$v=
//    {16'h0102, 64'h0, 32'hBBBB0002, 32'hAAAA0001}, hostIn$enq__RDY=0 until request transfer.
//  3 Backpressure: hostOut$enq__RDY toggling 1/0 and request$enq__RDY=0 for 10 cycles ->
//    no word lost or duplicated, output values stable while stalled.
//  4 Zero length: header 0x0500 both directions -> TX emits one word; RX goes FULL after header.
//  5 Overlength: header 0x0109 -> error=1, exactly 4 payload words used, error stays 1.
//  6 Reset mid-message: RST after 2 of 4 RX words -> next header starts fresh message, error=0.

Source files
------------

// File: rtl/bscant_pkg.sv
// Shared definitions for the portal pipe bridge.
// Widths of the 144-bit pipe message, header layout, FSM encodings and small
// helpers for the length rule used by both the TX and RX halves.
package bscant_pkg;

    localparam int HDR_W     = 16;
    localparam int PAYLOAD_W = 128;
    localparam int WORD_W    = 32;
    localparam int MAX_WORDS = PAYLOAD_W / WORD_W;
    localparam int PIPE_W    = HDR_W + PAYLOAD_W;

    // Word index within the payload, and log2(WORD_W) for building bit offsets.
    localparam int K_W     = 2;
    localparam int WORD_SH = 5;

    typedef struct packed {
        logic [7:0] method_id;
        logic [7:0] len_words;
    } pipe_hdr_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_HDR  = 2'd1,
        TX_DATA = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_HDR  = 2'd0,
        RX_DATA = 2'd1,
        RX_FULL = 2'd2
    } rx_state_t;

    // Number of payload words actually carried: lenWords saturated at MAX_WORDS.
    function automatic logic [7:0] clamp_len(input logic [7:0] len_words);
        if (len_words > 8'(MAX_WORDS)) begin
            return 8'(MAX_WORDS);
        end
        return len_words;
    endfunction

    function automatic logic is_overlength(input logic [7:0] len_words);
        return len_words > 8'(MAX_WORDS);
    endfunction

    // True when word index k is the final word of a message of len (len >= 1).
    function automatic logic is_last_word(input logic [K_W-1:0] k, input logic [7:0] len);
        return 8'(k) == (len - 8'd1);
    endfunction

endpackage

// File: rtl/l_pipe_word_ser.sv
// TX half of the pipe bridge: buffers one 144-bit message and emits it as a
// header word followed by lenWords (clamped) payload words, LSW first.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   msg_ena/msg    message offered (sampled only while msg_rdy=1)
//   msg_rdy        high in IDLE only
//   word_ena/word  word transfer (word_ena = valid & word_rdy), word value
//   word_rdy       downstream can take a word
//   state_dbg      current FSM state, for observation
// Handshake: a transfer happens in any cycle where ENA=1; ENA on an output is
// internal valid AND the peer's RDY; an input ENA is only honoured while our RDY=1.
module l_pipe_word_ser
    import bscant_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              msg_ena,
    input  logic [PIPE_W-1:0] msg,
    output logic              msg_rdy,
    output logic              word_ena,
    output logic [WORD_W-1:0] word,
    input  logic              word_rdy,
    output tx_state_t         state_dbg
);

    tx_state_t            state_q, state_d;
    logic [PIPE_W-1:0]    msg_q;
    logic [K_W-1:0]       k_q;
    logic [7:0]           len;
    logic [PAYLOAD_W-1:0] payload;

    assign len       = clamp_len(msg_q[PAYLOAD_W +: 8]);
    assign payload   = msg_q[PAYLOAD_W-1:0];
    assign state_dbg = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE: if (msg_ena) state_d = TX_HDR;
            TX_HDR:  if (word_ena) state_d = (len == 8'd0) ? TX_IDLE : TX_DATA;
            TX_DATA: if (word_ena && is_last_word(k_q, len)) state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_q <= '0;
            k_q   <= '0;
        end else begin
            if (state_q == TX_IDLE && msg_ena) begin
                msg_q <= msg;
            end
            if (state_q == TX_HDR && word_ena) begin
                k_q <= '0;
            end else if (state_q == TX_DATA && word_ena) begin
                k_q <= k_q + K_W'(1);
            end
        end
    end

    always_comb begin
        msg_rdy  = (state_q == TX_IDLE);
        word_ena = 1'b0;
        word     = '0;
        case (state_q)
            TX_HDR: begin
                word_ena = word_rdy;
                word     = {{(WORD_W-HDR_W){1'b0}}, msg_q[PIPE_W-1 -: HDR_W]};
            end
            TX_DATA: begin
                word_ena = word_rdy;
                word     = payload[{k_q, {WORD_SH{1'b0}}} +: WORD_W];
            end
            default: begin
                word_ena = 1'b0;
                word     = '0;
            end
        endcase
    end

endmodule

// File: rtl/l_host_pipe_bridge.sv
// Host-side endpoint of the 144-bit portal pipe.
// TX: indication messages are serialized into 32-bit host words (l_pipe_word_ser).
// RX: 32-bit host words are reassembled into one 144-bit request message.
// Ports:
//   CLK, RST                        clock, asynchronous active-high reset
//   indication_enq__ENA/_v/__RDY    144-bit message in
//   hostOut_enq__ENA/_v/__RDY       32-bit host word out
//   hostIn_enq__ENA/_v/__RDY        32-bit host word in
//   request_enq__ENA/_v/__RDY       144-bit message out
//   error                           sticky: some header had lenWords > MAX_WORDS
// Handshake: a transfer happens in any cycle where ENA=1; ENA on an output is
// internal valid AND the peer's RDY; an input ENA is only honoured while our RDY=1.
module l_host_pipe_bridge
    import bscant_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              indication_enq__ENA,
    input  logic [PIPE_W-1:0] indication_enq_v,
    output logic              indication_enq__RDY,
    output logic              hostOut_enq__ENA,
    output logic [WORD_W-1:0] hostOut_enq_v,
    input  logic              hostOut_enq__RDY,
    input  logic              hostIn_enq__ENA,
    input  logic [WORD_W-1:0] hostIn_enq_v,
    output logic              hostIn_enq__RDY,
    output logic              request_enq__ENA,
    output logic [PIPE_W-1:0] request_enq_v,
    input  logic              request_enq__RDY,
    output logic              error
);

    tx_state_t tx_state_dbg;

    l_pipe_word_ser u_tx (
        .clk       (CLK),
        .rst       (RST),
        .msg_ena   (indication_enq__ENA),
        .msg       (indication_enq_v),
        .msg_rdy   (indication_enq__RDY),
        .word_ena  (hostOut_enq__ENA),
        .word      (hostOut_enq_v),
        .word_rdy  (hostOut_enq__RDY),
        .state_dbg (tx_state_dbg)
    );

    // ---------------- RX half ----------------
    rx_state_t            rx_state_q, rx_state_d;
    logic [HDR_W-1:0]     hdr_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [K_W-1:0]       k_q;
    logic [7:0]           rx_len;
    pipe_hdr_t            rx_hdr_in;
    logic                 rx_acc;
    logic                 tx_acc;
    logic                 error_q;
    logic                 unused_bits;

    assign rx_hdr_in   = pipe_hdr_t'(hostIn_enq_v[HDR_W-1:0]);
    assign rx_len      = clamp_len(hdr_q[7:0]);
    assign rx_acc      = hostIn_enq__ENA & hostIn_enq__RDY;
    assign tx_acc      = indication_enq__ENA & indication_enq__RDY;
    // Upper half of a header word and method id are carried, not interpreted.
    assign unused_bits = ^{hostIn_enq_v[WORD_W-1:HDR_W], rx_hdr_in.method_id, tx_state_dbg};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_state_q <= RX_HDR;
        end else begin
            rx_state_q <= rx_state_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_HDR:  if (rx_acc) rx_state_d = (clamp_len(rx_hdr_in.len_words) == 8'd0) ? RX_FULL : RX_DATA;
            RX_DATA: if (rx_acc && is_last_word(k_q, rx_len)) rx_state_d = RX_FULL;
            RX_FULL: if (request_enq__ENA) rx_state_d = RX_HDR;
            default: rx_state_d = RX_HDR;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hdr_q     <= '0;
            payload_q <= '0;
            k_q       <= '0;
        end else if (rx_acc) begin
            if (rx_state_q == RX_HDR) begin
                // Clear the payload so words beyond lenWords read as zero.
                hdr_q     <= hostIn_enq_v[HDR_W-1:0];
                payload_q <= '0;
                k_q       <= '0;
            end else if (rx_state_q == RX_DATA) begin
                payload_q[{k_q, {WORD_SH{1'b0}}} +: WORD_W] <= hostIn_enq_v;
                k_q <= k_q + K_W'(1);
            end
        end
    end

    always_comb begin
        hostIn_enq__RDY  = (rx_state_q != RX_FULL);
        request_enq__ENA = 1'b0;
        request_enq_v    = '0;
        if (rx_state_q == RX_FULL) begin
            request_enq__ENA = request_enq__RDY;
            request_enq_v    = {hdr_q, payload_q};
        end
    end

    // ---------------- sticky error ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            error_q <= 1'b0;
        end else if ((tx_acc && is_overlength(indication_enq_v[PAYLOAD_W +: 8])) ||
                     (rx_acc && rx_state_q == RX_HDR && is_overlength(rx_hdr_in.len_words))) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;

endmodule

// File: tb/tb_l_host_pipe_bridge.sv
module tb_l_host_pipe_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic         ind_ena;
    logic [143:0] ind_v;
    logic         ind_rdy;
    logic         host_ena;
    logic [31:0]  host_v;
    logic         host_rdy;
    logic         hin_ena;
    logic [31:0]  hin_v;
    logic         hin_rdy;
    logic         req_ena;
    logic [143:0] req_v;
    logic         req_rdy;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    l_host_pipe_bridge dut (
        .CLK                 (clk),
        .RST                 (rst),
        .indication_enq__ENA (ind_ena),
        .indication_enq_v    (ind_v),
        .indication_enq__RDY (ind_rdy),
        .hostOut_enq__ENA    (host_ena),
        .hostOut_enq_v       (host_v),
        .hostOut_enq__RDY    (host_rdy),
        .hostIn_enq__ENA     (hin_ena),
        .hostIn_enq_v        (hin_v),
        .hostIn_enq__RDY     (hin_rdy),
        .request_enq__ENA    (req_ena),
        .request_enq_v       (req_v),
        .request_enq__RDY    (req_rdy),
        .error               (err)
    );

    typedef struct {
        logic         ind_ena;
        logic [143:0] ind_v;
        logic         host_rdy;
        logic         hin_ena;
        logic [31:0]  hin_v;
        logic         req_rdy;
        logic         e_ind_rdy;
        logic         e_host_ena;
        logic [31:0]  e_host_v;
        logic         e_hin_rdy;
        logic         e_req_ena;
        logic [143:0] e_req_v;
        logic         e_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Entered just after a negedge; leaves at the next negedge with hin_ena low.
    task automatic rx_word(input logic [31:0] w);
        hin_ena = 1'b1;
        hin_v   = w;
        #1 chk("rx word rdy", hin_rdy, 1'b1);
        @(negedge clk);
        hin_ena = 1'b0;
    endtask

    // Holds the request for ncyc stalled cycles, then lets it transfer.
    task automatic rx_expect(input logic [143:0] exp, input int ncyc);
        req_rdy = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            #1;
            chk("rx stall value", req_v, exp);
            chk("rx stall ena", req_ena, 1'b0);
            chk("rx full rdy", hin_rdy, 1'b0);
            @(negedge clk);
        end
        req_rdy = 1'b1;
        #1;
        chk("rx req ena", req_ena, 1'b1);
        chk("rx req value", req_v, exp);
        @(negedge clk);
        req_rdy = 1'b0;
        #1;
        chk("rx back to hdr", hin_rdy, 1'b1);
        chk("rx ena after xfer", req_ena, 1'b0);
        @(negedge clk);
    endtask

    // Sends one indication and drains the host words against exp_q.
    task automatic tx_send(input logic [15:0] hdr, input logic [127:0] pl, input bit toggle);
        int n;
        logic [31:0] w;
        n = (hdr[7:0] > 8'd4) ? 4 : int'(hdr[7:0]);
        exp_q.delete();
        exp_q.push_back({16'h0, hdr});
        for (int k = 0; k < n; k++) exp_q.push_back(pl[32*k +: 32]);
        ind_ena  = 1'b1;
        ind_v    = {hdr, pl};
        host_rdy = 1'b0;
        #1 chk("tx accept rdy", ind_rdy, 1'b1);
        @(negedge clk);
        ind_ena = 1'b0;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            host_rdy = toggle ? (c % 2 == 0) : 1'b1;
            #1;
            chk("tx busy rdy", ind_rdy, 1'b0);
            if (host_rdy) begin
                w = exp_q.pop_front();
                chk("tx word ena", host_ena, 1'b1);
                chk("tx word value", host_v, w);
            end else begin
                chk("tx stalled ena", host_ena, 1'b0);
                chk("tx stalled value", host_v, exp_q[0]);
            end
            @(negedge clk);
        end
        chk("tx drained", exp_q.size(), 0);
        host_rdy = 1'b1;
        #1;
        chk("tx idle rdy", ind_rdy, 1'b1);
        chk("tx idle ena", host_ena, 1'b0);
        @(negedge clk);
        host_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [143:0] req1;
        logic [143:0] txm;
        req1 = {16'h0102, 64'h0, 32'hBBBB0002, 32'hAAAA0001};
        txm  = {16'h0203, 128'h4444_4444_3333_3333_2222_2222_1111_1111};
        //           ind  ind_v  hrdy hin  hin_v         req | ind_rdy hena hv  hin_rdy req_ena req_v  err
        vecs[0] = '{1'b1, txm,   1'b1, 1'b1, 32'h00000102, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 144'h0, 1'b0};
        vecs[1] = '{1'b0, 144'h0, 1'b1, 1'b1, 32'hAAAA0001, 1'b1, 1'b0, 1'b1, 32'h00000203, 1'b1, 1'b0, 144'h0, 1'b0};
        vecs[2] = '{1'b0, 144'h0, 1'b1, 1'b1, 32'hBBBB0002, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b1, 1'b0, 144'h0, 1'b0};
        vecs[3] = '{1'b0, 144'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0, req1,   1'b0};
        vecs[4] = '{1'b0, 144'h0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h33333333, 1'b0, 1'b1, req1,   1'b0};
        vecs[5] = '{1'b0, 144'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 144'h0, 1'b0};

        // Clock/reset
        rst = 1'b1; ind_ena = 1'b0; ind_v = '0; host_rdy = 1'b0;
        hin_ena = 1'b0; hin_v = '0; req_rdy = 1'b0;
        #2;
        chk("reset ind_rdy", ind_rdy, 1'b1);
        chk("reset hin_rdy", hin_rdy, 1'b1);
        chk("reset host_ena", host_ena, 1'b0);
        chk("reset host_v", host_v, 32'h0);
        chk("reset req_ena", req_ena, 1'b0);
        chk("reset req_v", req_v, 144'h0);
        chk("reset error", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic TX and RX in parallel, cycle by cycle
        for (int i = 0; i < 6; i++) begin
            ind_ena  = vecs[i].ind_ena;
            ind_v    = vecs[i].ind_v;
            host_rdy = vecs[i].host_rdy;
            hin_ena  = vecs[i].hin_ena;
            hin_v    = vecs[i].hin_v;
            req_rdy  = vecs[i].req_rdy;
            #1;
            chk($sformatf("row%0d ind_rdy", i), ind_rdy, vecs[i].e_ind_rdy);
            chk($sformatf("row%0d host_ena", i), host_ena, vecs[i].e_host_ena);
            chk($sformatf("row%0d host_v", i), host_v, vecs[i].e_host_v);
            chk($sformatf("row%0d hin_rdy", i), hin_rdy, vecs[i].e_hin_rdy);
            chk($sformatf("row%0d req_ena", i), req_ena, vecs[i].e_req_ena);
            chk($sformatf("row%0d req_v", i), req_v, vecs[i].e_req_v);
            chk($sformatf("row%0d error", i), err, vecs[i].e_err);
            @(negedge clk);
        end
        ind_ena = 1'b0; host_rdy = 1'b0; hin_ena = 1'b0; req_rdy = 1'b0;

        // Backpressure: toggling host ready on TX, 10-cycle request stall on RX
        tx_send(16'h0404, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 1'b1);
        rx_word(32'h00000001);
        rx_word(32'hCAFEF00D);
        rx_expect({16'h0001, 96'h0, 32'hCAFEF00D}, 10);

        // Zero length in both directions; upper header bits ignored on RX
        tx_send(16'h0500, 128'hDEAD_BEEF, 1'b0);
        rx_word(32'hFFFF0500);
        rx_expect({16'h0500, 128'h0}, 1);

        // Overlength: only four payload words used, error sticks
        chk("err before overlength", err, 1'b0);
        rx_word(32'h00000109);
        #1 chk("err after overlength hdr", err, 1'b1);
        for (int j = 0; j < 5; j++) begin
            hin_ena = 1'b1;
            hin_v   = 32'h50000000 + j;
            #1 chk($sformatf("overlength word%0d rdy", j), hin_rdy, (j < 4) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        hin_ena = 1'b0;
        rx_expect({16'h0109, 32'h50000003, 32'h50000002, 32'h50000001, 32'h50000000}, 1);
        tx_send(16'h0109, 128'h99999999_88888888_77777777_66666666, 1'b0);
        chk("err sticky", err, 1'b1);

        // Reset in the middle of an RX message
        rx_word(32'h00000104);
        rx_word(32'h00000011);
        rx_word(32'h00000022);
        req_rdy = 1'b1;
        rst = 1'b1;
        #1;
        chk("midreset error", err, 1'b0);
        chk("midreset hin_rdy", hin_rdy, 1'b1);
        chk("midreset req_ena", req_ena, 1'b0);
        chk("midreset req_v", req_v, 144'h0);
        chk("midreset ind_rdy", ind_rdy, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        req_rdy = 1'b0;
        @(negedge clk);
        rx_word(32'h00000101);
        rx_word(32'h12345678);
        rx_expect({16'h0101, 96'h0, 32'h12345678}, 1);
        chk("error after fresh msg", err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
